turn_signal_scheduler: RTL and testbench

TURN_SIGNAL_SCHEDULER -- requirements
Module: turn_signal_scheduler

---
 rtl/turn_sig_pkg.sv | 31 +++
 rtl/tick_prescaler.sv | 29 ++
 rtl/turn_signal_scheduler.sv | 109 ++++++++++
 tb/tb_turn_signal_scheduler.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/turn_sig_pkg.sv
// Shared types for the turn signal scheduler: mode encoding, lamp phase type and
// the request arbitration rule.
package turn_sig_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LEFT  = 2'b01,
        RIGHT = 2'b10,
        HAZ   = 2'b11
    } mode_e;

    typedef logic [1:0] phase_t;

    localparam phase_t PHASE_LAST = 2'd3;

    // Hazard wins, and both sides together count as a hazard request.
    function automatic mode_e arbitrate(input logic left, input logic right, input logic haz);
        mode_e w_res;
        if (haz || (left && right)) begin
            w_res = HAZ;
        end else if (left) begin
            w_res = LEFT;
        end else if (right) begin
            w_res = RIGHT;
        end else begin
            w_res = IDLE;
        end
        return w_res;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Lamp-step prescaler: counts 0..TICK_DIV-1 while enabled and flags the last count.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc
);

    localparam int unsigned CntW = $clog2(TICK_DIV);
    localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] r_cnt;

    assign o_tc = i_enable && (r_cnt == CntLast);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= o_tc ? '0 : r_cnt + CntW'(1);
        end
    end

endmodule

// File: rtl/turn_signal_scheduler.sv
// Turn signal sequencer: arbitrates left/right/hazard requests and steps a 4-phase lamp
// sequence every TICK_DIV cycles. Define TURN_SCHED_CANCEL_EN to let a dropped request abort.
module turn_signal_scheduler
    import turn_sig_pkg::*;
#(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       left_sw,
    input  logic       right_sw,
    input  logic       haz_sw,
    output logic [1:0] mode,
    output logic [1:0] phase,
    output logic       step,
    output logic       busy
);

    mode_e  r_mode;
    mode_e  w_mode_nxt;
    mode_e  w_arb;
    phase_t r_phase;
    phase_t w_phase_nxt;
    logic   r_step;
    logic   w_step_nxt;
    logic   r_busy;
    logic   w_tc;
    logic   w_clear;
    logic   w_active;
    logic   w_preempt;
    logic   w_cancel;
    logic   w_wrap;

    assign w_arb     = arbitrate(left_sw, right_sw, haz_sw);
    assign w_active  = (r_mode != IDLE);
    assign w_preempt = haz_sw && ((r_mode == LEFT) || (r_mode == RIGHT));
    assign w_wrap    = w_tc && (r_phase == PHASE_LAST);

`ifdef TURN_SCHED_CANCEL_EN
    always_comb begin
        w_cancel = 1'b0;
        case (r_mode)
            LEFT:    w_cancel = !left_sw;
            RIGHT:   w_cancel = !right_sw;
            HAZ:     w_cancel = !(haz_sw || (left_sw && right_sw));
            default: w_cancel = 1'b0;
        endcase
    end
`else
    assign w_cancel = 1'b0;
`endif

    // Any (re)entry restarts the prescaler so the first step lands TICK_DIV cycles later.
    assign w_clear = !w_active || w_preempt || w_cancel;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .i_clk    (clk),
        .i_rst_n  (reset),
        .i_clear  (w_clear),
        .i_enable (w_active),
        .o_tc     (w_tc)
    );

    always_comb begin
        w_mode_nxt  = r_mode;
        w_phase_nxt = r_phase;
        w_step_nxt  = 1'b0;
        if (!w_active) begin
            w_mode_nxt  = w_arb;
            w_phase_nxt = '0;
        end else if (w_preempt) begin
            w_mode_nxt  = HAZ;
            w_phase_nxt = '0;
        end else if (w_cancel) begin
            w_mode_nxt  = IDLE;
            w_phase_nxt = '0;
        end else if (w_tc) begin
            w_phase_nxt = r_phase + 2'd1;
            w_step_nxt  = 1'b1;
            if (w_wrap) begin
                w_mode_nxt = w_arb;
                // Step stays low when the wrap drops back to IDLE.
                w_step_nxt = (w_arb != IDLE);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode  <= IDLE;
            r_phase <= '0;
            r_step  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_mode  <= w_mode_nxt;
            r_phase <= w_phase_nxt;
            r_step  <= w_step_nxt;
            r_busy  <= (w_mode_nxt != IDLE);
        end
    end

    assign mode  = r_mode;
    assign phase = r_phase;
    assign step  = r_step;
    assign busy  = r_busy;

endmodule

// File: tb/tb_turn_signal_scheduler.sv
// Directed plus randomized bench for turn_signal_scheduler against a cycle-age reference model.
module tb_turn_signal_scheduler;

    localparam int unsigned TD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       left_sw = 1'b0;
    logic       right_sw = 1'b0;
    logic       haz_sw = 1'b0;
    logic [1:0] mode;
    logic [1:0] phase;
    logic       step;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    // Model: mode as 0..3 and the number of cycles since the sequence was (re)entered.
    int m_mode = 0;
    int m_age = 0;
    int m_phase = 0;
    bit m_step = 1'b0;

    turn_signal_scheduler #(
        .TICK_DIV (TD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .left_sw  (left_sw),
        .right_sw (right_sw),
        .haz_sw   (haz_sw),
        .mode     (mode),
        .phase    (phase),
        .step     (step),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic int arb(bit l, bit r, bit h);
        if (h || (l && r)) return 3;
        if (l) return 1;
        if (r) return 2;
        return 0;
    endfunction

    function automatic bit owner_gone(int md, bit l, bit r, bit h);
        if (md == 1) return !l;
        if (md == 2) return !r;
        if (md == 3) return !(h || (l && r));
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_age   = 0;
        m_phase = 0;
        m_step  = 1'b0;
    endtask

    task automatic model_edge(bit l, bit r, bit h);
        int a;
        bit gone;
        a = arb(l, r, h);
        gone = owner_gone(m_mode, l, r, h);
        m_step = 1'b0;
        if (m_mode == 0) begin
            m_mode = a;
            m_age  = 0;
        end else if (h && m_mode != 3) begin
            m_mode = 3;
            m_age  = 0;
`ifdef TURN_SCHED_CANCEL_EN
        end else if (gone) begin
            m_mode = 0;
            m_age  = 0;
`endif
        end else begin
            m_age++;
            if (m_age == 4 * TD) begin
                m_mode = a;
                m_age  = 0;
                m_step = (a != 0);
            end else begin
                m_step = (m_age % TD == 0);
            end
        end
        m_phase = (m_age / TD) % 4;
    endtask

    task automatic chk(string tag, logic [1:0] obs, logic [1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".mode"}, mode, 2'(m_mode));
        chk({tag, ".phase"}, phase, 2'(m_phase));
        chk({tag, ".step"}, {1'b0, step}, {1'b0, m_step});
        chk({tag, ".busy"}, {1'b0, busy}, {1'b0, m_mode != 0});
    endtask

    // Apply inputs for one edge, advance the model and compare 1 time unit after the edge.
    task automatic cycle(string tag, bit l, bit r, bit h);
        left_sw  = l;
        right_sw = r;
        haz_sw   = h;
        @(posedge clk);
        if (!reset) model_reset();
        else model_edge(l, r, h);
        #1;
        check_all(tag);
    endtask

    initial begin
        bit l;
        bit r;
        bit h;
        int guard;

        // Reset and idle
        #1 reset = 1'b0;
        #1 check_all("rst_async");
        for (int i = 0; i < 3; i++) cycle("rst_hold", 1'b1, 1'b0, 1'b1);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) cycle("idle", 1'b0, 1'b0, 1'b0);

        // Left sequence: two full rounds
        for (int i = 0; i < 8 * TD + 2; i++) cycle("left", 1'b1, 1'b0, 1'b0);

        // Hazard preemption at phase 2
        guard = 0;
        while (!(m_mode == 1 && m_phase == 2) && guard < 64) begin
            cycle("left_to_p2", 1'b1, 1'b0, 1'b0);
            guard++;
        end
        for (int i = 0; i < 2 * TD + 1; i++) cycle("preempt", 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5 * TD; i++) cycle("drain", 1'b0, 1'b0, 1'b0);

        // Both sides from idle, released at phase 1
        guard = 0;
        do begin
            cycle("both", 1'b1, 1'b1, 1'b0);
            guard++;
        end while (!(m_mode == 3 && m_phase == 1) && guard < 64);
        for (int i = 0; i < 4 * TD; i++) cycle("both_rel", 1'b0, 1'b0, 1'b0);

        // Re-arbitration at wrap: left, then right only from phase 2
        guard = 0;
        do begin
            cycle("rearb_l", 1'b1, 1'b0, 1'b0);
            guard++;
        end while (!(m_mode == 1 && m_phase == 2) && guard < 64);
        for (int i = 0; i < 4 * TD; i++) cycle("rearb_r", 1'b0, 1'b1, 1'b0);

        // Reset in the middle of a right sequence
        guard = 0;
        while (!(m_mode == 2 && m_phase == 2) && guard < 64) begin
            cycle("right_to_p2", 1'b0, 1'b1, 1'b0);
            guard++;
        end
        #2 reset = 1'b0;
        model_reset();
        #1 check_all("rst_mid");
        cycle("rst_mid_hold", 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        for (int i = 0; i < TD + 1; i++) cycle("rst_resume", 1'b0, 1'b1, 1'b0);

        // Random level requests that dwell for several cycles
        l = 1'b0;
        r = 1'b0;
        h = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) l = ~l;
            if ($urandom_range(0, 7) == 0) r = ~r;
            if ($urandom_range(0, 23) == 0) h = ~h;
            cycle("rand", l, r, h);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
